// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the port identifiers, default bus widths (12-bit word address and
// 32-bit data, matching the processor's dmem) and the hold-counter helper.
package dmem_arbiter_pkg;

    localparam logic PORT_CPU   = 1'b0;
    localparam logic PORT_AUX   = 1'b1;

    localparam int   ADDR_W_DEF = 12;
    localparam int   DATA_W_DEF = 32;

    localparam int              HOLD_W   = 4;
    localparam logic [HOLD_W-1:0] HOLD_SAT = 4'd15;

    // Saturating increment of the back-to-back grant counter.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
        logic [HOLD_W-1:0] res;
        if (cnt == HOLD_SAT) begin
            res = HOLD_SAT;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker with a bounded burst lock for port 1.
// Ports:
//   clock, reset   : master clock, synchronous active-high reset
//   req0, req1     : requests from port 0 (CPU) and port 1 (aux master)
//   lock1          : port 1 asks for back-to-back grants
//   gnt0, gnt1     : one-hot-or-zero grant, combinational, low during reset
module rr_arb2
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic              last_gnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              lock_win_s;

    // The lock only extends a run that port 1 already owns, and only up to
    // HOLD_LIMIT grants in a row; after that port 0 gets its turn.
    assign lock_win_s = lock1 & req1 & (last_gnt_r == PORT_AUX) & (hold_cnt_r < HOLD_LIMIT);

    // Grant selection: lock override first, then round-robin on contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_win_s) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (last_gnt_r == PORT_AUX) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
        end
    end

    // Round-robin history and consecutive-grant counter; idle cycles hold both.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_r <= PORT_AUX;
            hold_cnt_r <= 4'd0;
        end else if (gnt0 || gnt1) begin
            last_gnt_r <= gnt1;
            if (gnt1 != last_gnt_r) begin
                hold_cnt_r <= 4'd1;
            end else begin
                hold_cnt_r <= hold_inc(hold_cnt_r);
            end
        end else begin
            last_gnt_r <= last_gnt_r;
            hold_cnt_r <= hold_cnt_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path
// (port 0) and an auxiliary loader/debug/IO master (port 1).
// Ports:
//   clock, reset              : master clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN     : request, write enable, address, write data
//   gntN                      : granted this cycle (combinational)
//   rvalidN/rdataN            : read data return, one cycle after the grant
//   lock1                     : port 1 burst lock
//   address_dmem/data/wren    : drive to the dmem
//   q_dmem                    : dmem read data, valid one cycle after address
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              lock1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    logic rd_pend0_r;
    logic rd_pend1_r;

    rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .lock1 (lock1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Route the granted port onto the dmem bus; idle bus is all zeros.
    always_comb begin
        address_dmem = {ADDR_W{1'b0}};
        data         = {DATA_W{1'b0}};
        wren         = 1'b0;
        if (gnt0) begin
            address_dmem = addr0;
            data         = wdata0;
            wren         = we0;
        end else if (gnt1) begin
            address_dmem = addr1;
            data         = wdata1;
            wren         = we1;
        end else begin
            wren         = 1'b0;
        end
    end

    // Remember which port issued a read so the next cycle's q_dmem is steered
    // back to it; reset drops anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend0_r <= 1'b0;
            rd_pend1_r <= 1'b0;
        end else begin
            rd_pend0_r <= gnt0 & ~we0;
            rd_pend1_r <= gnt1 & ~we1;
        end
    end

    // The inactive port sees zero data so nothing leaks across ports.
    assign rvalid0 = rd_pend0_r;
    assign rvalid1 = rd_pend1_r;
    assign rdata0  = rd_pend0_r ? q_dmem : {DATA_W{1'b0}};
    assign rdata1  = rd_pend1_r ? q_dmem : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic compared against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, q_dmem = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, wren;
    logic [DW-1:0] rdata0, rdata1, data;
    logic [AW-1:0] address_dmem;

    int checks   = 0;
    int failures = 0;

    // Reference model state: kept as plain integers.
    int m_last;
    int m_hold;
    int m_g;
    bit m_pend0, m_pend1;
    bit track;
    int w0, w1, max_w0, max_w1;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock1(lock1), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which port should win right now (-1 = none), straight from the rules.
    function automatic int exp_grant();
        if (reset) return -1;
        if (req1 && lock1 && m_last == 1 && m_hold < MH) return 1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic check_cycle();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        #1;
        m_g = exp_grant();
        ea = '0; ed = '0; ew = 1'b0;
        if (m_g == 0) begin ea = addr0; ed = wdata0; ew = we0; end
        if (m_g == 1) begin ea = addr1; ed = wdata1; ew = we1; end
        chk("gnt0", gnt0, m_g == 0);
        chk("gnt1", gnt1, m_g == 1);
        chk("address_dmem", address_dmem, ea);
        chk("data", data, ed);
        chk("wren", wren, ew);
        chk("rvalid0", rvalid0, m_pend0);
        chk("rvalid1", rvalid1, m_pend1);
        chk("rdata0", rdata0, m_pend0 ? q_dmem : 32'h0);
        chk("rdata1", rdata1, m_pend1 ? q_dmem : 32'h0);
        if (track) begin
            if (req0 && m_g != 0) w0++; else w0 = 0;
            if (req1 && m_g != 1) w1++; else w1 = 0;
            if (w0 > max_w0) max_w0 = w0;
            if (w1 > max_w1) max_w1 = w1;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            m_last = 1; m_hold = 0; m_pend0 = 1'b0; m_pend1 = 1'b0;
        end else begin
            m_pend0 = (m_g == 0) && !we0;
            m_pend1 = (m_g == 1) && !we1;
            if (m_g >= 0) begin
                if (m_g != m_last) m_hold = 1;
                else m_hold = (m_hold + 1 > 15) ? 15 : m_hold + 1;
                m_last = m_g;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        check_cycle();
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        advance();
        reset = 1'b0;
    endtask

    task automatic new_req0();
        req0 = ($urandom_range(0, 3) != 0);
        we0 = $urandom_range(0, 1); addr0 = AW'($urandom); wdata0 = $urandom;
    endtask

    task automatic new_req1();
        req1 = ($urandom_range(0, 3) != 0);
        we1 = $urandom_range(0, 1); addr1 = AW'($urandom); wdata1 = $urandom;
    endtask

    initial begin
        logic [5:0] lock_pat;
        logic [3:0] alt_pat;
        lock_pat = 6'b101111;
        alt_pat  = 4'b0101;
        track = 1'b0; w0 = 0; w1 = 0; max_w0 = 0; max_w1 = 0; m_g = -1;

        // Initial reset, then model starts from the documented reset state.
        repeat (2) @(posedge clock);
        m_last = 1; m_hold = 0; m_pend0 = 1'b0; m_pend1 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1;
        do_reset();
        req0 = 1'b0; req1 = 1'b0;
        check_cycle();
        chk("post_rst_rvalid0", rvalid0, 1'b0);
        chk("post_rst_rvalid1", rvalid1, 1'b0);
        advance();

        // Single port 0 read with 1-cycle return.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        check_cycle();
        chk("t1_gnt0", gnt0, 1'b1);
        chk("t1_addr", address_dmem, 12'h010);
        chk("t1_wren", wren, 1'b0);
        advance();
        req0 = 1'b0; q_dmem = 32'hDEADBEEF;
        check_cycle();
        chk("t1_rvalid0", rvalid0, 1'b1);
        chk("t1_rdata0", rdata0, 32'hDEADBEEF);
        chk("t1_rvalid1", rvalid1, 1'b0);
        advance();

        // Continuous contention, no lock: 0,1,0,1.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q_dmem = $urandom;
            check_cycle();
            chk("alt_gnt0", gnt0, alt_pat[k]);
            chk("alt_excl", gnt0 & gnt1, 1'b0);
            advance();
        end

        // Locked burst: four port 1 grants, one port 0, then port 1 again.
        do_reset();
        lock1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            q_dmem = $urandom;
            check_cycle();
            chk("lock_gnt1", gnt1, lock_pat[k]);
            advance();
        end
        lock1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        check_cycle();
        advance();

        // Port 1 write with port 0 idle.
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0FF; wdata1 = 32'h12345678;
        check_cycle();
        chk("wr_gnt1", gnt1, 1'b1);
        chk("wr_wren", wren, 1'b1);
        chk("wr_addr", address_dmem, 12'h0FF);
        chk("wr_data", data, 32'h12345678);
        advance();
        req1 = 1'b0; we1 = 1'b0;
        check_cycle();
        chk("wr_no_rvalid1", rvalid1, 1'b0);
        advance();

        // Reset right after a port 0 read grant drops the pending read.
        do_reset();
        req0 = 1'b1; we0 = 1'b0;
        check_cycle();
        chk("rr_gnt0", gnt0, 1'b1);
        advance();
        reset = 1'b1; req1 = 1'b1; we1 = 1'b0;
        check_cycle();
        chk("rr_gnt0_in_rst", gnt0, 1'b0);
        chk("rr_gnt1_in_rst", gnt1, 1'b0);
        chk("rr_rvalid0_in_rst", rvalid0, 1'b1);
        advance();
        reset = 1'b0;
        check_cycle();
        chk("rr_rvalid0_dropped", rvalid0, 1'b0);
        chk("rr_port0_wins", gnt0, 1'b1);
        advance();
        req0 = 1'b0; req1 = 1'b0;
        check_cycle();
        advance();

        // Back-to-back reads: port 0 then port 1.
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
        check_cycle();
        advance();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h456; q_dmem = 32'hA5A5_0001;
        check_cycle();
        chk("b2b_rdata0", rdata0, 32'hA5A5_0001);
        chk("b2b_rdata1_zero", rdata1, 32'h0);
        chk("b2b_gnt1", gnt1, 1'b1);
        advance();
        req1 = 1'b0; q_dmem = 32'h5A5A_0002;
        check_cycle();
        chk("b2b_rvalid1", rvalid1, 1'b1);
        chk("b2b_rdata1", rdata1, 32'h5A5A_0002);
        chk("b2b_rdata0_zero", rdata0, 32'h0);
        advance();

        // Randomized traffic with requesters honouring the handshake.
        track = 1'b1;
        new_req0(); new_req1();
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) lock1 = $urandom_range(0, 1);
            q_dmem = $urandom;
            check_cycle();
            advance();
            if (m_g == 0 || !req0) new_req0();
            if (m_g == 1 || !req1) new_req1();
        end
        chk("fair_port0_wait_le_max", max_w0 <= MH, 1'b1);
        chk("fair_port1_wait_le_1", max_w1 <= 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
